ceespu_int_ctrl: RTL and testbench
==================================

CEESPU_INT_CTRL -- requirements
Module: ceespu_int_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of interrupt lines (legal 1..16).
REQ-002 SHALL have parameter EDGE_MASK, default 0, NUM_IRQ bits; bit=1 makes that line rising-edge triggered, bit=0 level triggered.
REQ-003 SHALL have parameter VEC_BASE, default 14'h0000, word address of vector 0.
REQ-004 SHALL have parameter VEC_STRIDE, default 14'h0004, word-address spacing between vectors.
REQ-005 SHALL have parameter RESET_EN, default 1, reset value of the global interrupt enable.
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 SHALL have I_clk  input  1  clock; all state updates on its rising edge.
REQ-008 SHALL have I_rst  input  1  synchronous active-high reset.
REQ-009 SHALL have I_irq  input  NUM_IRQ  raw interrupt lines.
REQ-010 SHALL have I_stall  input  1  pipeline stall; blocks ack, EINT, RETI and mask writes.
REQ-011 SHALL have I_justBranched  input  1  suppresses O_int_req this cycle.
REQ-012 SHALL have I_int_ack  input  1  decode took the interrupt.
REQ-013 SHALL have I_eint_valid / I_eint_value  input  1/1  EINT instruction and its enable bit.
REQ-014 SHALL have I_reti  input  1  return-from-interrupt (branch via c17) retired.
REQ-015 SHALL have I_mask_we / I_mask_data  input  1/NUM_IRQ  per-line mask write.
REQ-016 SHALL have O_int_req  output  1  interrupt request to decode.
REQ-017 SHALL have O_branchAddress  output  14  vector word address, valid while O_int_req=1.
REQ-018 SHALL have O_active_id  output  clog2(NUM_IRQ) (min 1)  index of latched or in-service line.
REQ-019 SHALL have O_in_service / O_int_en  output  1/1  handler active / global enable.
REQ-020 SHALL have O_pending  output  NUM_IRQ  pending bits before masking.

Function
REQ-021 SHALL compute pending[i] = I_irq[i] for level lines; for edge lines, set on registered 0->1 of I_irq[i], held until cleared.
REQ-022 SHALL define eligible = pending & mask; winner = lowest set index of eligible (index 0 highest priority).
REQ-023 SHALL implement states IDLE, REQ, SERVICE.
REQ-024 IDLE->REQ when O_int_en=1 and eligible!=0; latch winner into O_active_id and O_branchAddress = VEC_BASE + id*VEC_STRIDE (14-bit, wrap mod 2^14).
REQ-025 REQ: O_int_req = !I_justBranched; O_active_id/O_branchAddress held stable regardless of pending or mask changes.
REQ-026 Ack accepted only when state=REQ, O_int_req=1, I_int_ack=1, I_stall=0; I_int_ack at any other time SHALL be ignored.
REQ-027 On accepted ack: ->SERVICE next cycle, O_int_en<=0, O_in_service<=1, clear pending[id] if edge line.
REQ-028 A new rising edge on line id in the ack cycle SHALL leave pending[id] set (set wins over clear).
REQ-029 SERVICE: no request raised; I_reti with I_stall=0 ->IDLE, O_int_en<=1, O_in_service<=0.
REQ-030 I_eint_valid with I_stall=0 SHALL load O_int_en<=I_eint_value in any state; simultaneous accepted ack overrides (O_int_en<=0).
REQ-031 REQ whose line deasserts (level) or O_int_en cleared by EINT before ack SHALL still be honoured (no withdraw).
REQ-032 I_reti outside SERVICE SHALL be ignored; I_mask_we with I_stall=0 loads mask next cycle.
REQ-033 Request latency: eligible line at cycle N (IDLE, enabled) -> O_int_req=1 at N+1.

Reset
REQ-034 On I_rst=1 at a clock edge: state=IDLE, mask=all ones, edge pending=0, edge history=0, O_int_req=0, O_in_service=0, O_active_id=0, O_branchAddress=VEC_BASE, O_int_en=RESET_EN.
REQ-035 Reset mid-REQ or mid-SERVICE SHALL abandon the interrupt with no ack/return needed; I_rst overrides all other inputs.

Verification
REQ-036 NUM_IRQ=4, I_irq=4'b0110 level, enabled -> next cycle O_int_req=1, O_active_id=1, O_branchAddress=14'h0004.
REQ-037 In REQ, pulse I_justBranched -> O_int_req=0 that cycle, 1 next; ack with I_stall=1 -> stays REQ; ack with I_stall=0 -> SERVICE, O_int_en=0.
REQ-038 EDGE_MASK=4'b1000, pulse I_irq[3] one cycle -> pending[3]=1 held; after ack pending[3]=0; second edge in ack cycle -> pending[3] stays 1.
REQ-039 SERVICE with I_irq[0]=1 -> no O_int_req until I_reti; after I_reti O_int_req=1 with id 0 two cycles later.
REQ-040 Mask write 4'b1110 with I_irq=4'b0001 -> no request; EINT 0 then I_irq[2]=1 -> no request until EINT 1.
REQ-041 Assert I_rst in SERVICE -> next cycle IDLE, O_int_en=RESET_EN, O_in_service=0, O_int_req=0.

Source files
------------

// File: rtl/ceespu_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ceespu_int_ctrl
// Brief    : Prioritised interrupt controller with level/edge lines,
//            per-line mask, global enable and single-level handler nesting.
// Revision : 1.0
// ============================================================================
module ceespu_int_ctrl #(
  parameter int                   NUM_IRQ    = 4,
  parameter logic [NUM_IRQ-1:0]   EDGE_MASK  = '0,
  parameter logic [13:0]          VEC_BASE   = 14'h0000,
  parameter logic [13:0]          VEC_STRIDE = 14'h0004,
  parameter logic                 RESET_EN   = 1'b1,
  localparam int                  IDW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic [NUM_IRQ-1:0] I_irq,
  input  logic               I_stall,
  input  logic               I_justBranched,
  input  logic               I_int_ack,
  input  logic               I_eint_valid,
  input  logic               I_eint_value,
  input  logic               I_reti,
  input  logic               I_mask_we,
  input  logic [NUM_IRQ-1:0] I_mask_data,
  output logic               O_int_req,
  output logic [13:0]        O_branchAddress,
  output logic [IDW-1:0]     O_active_id,
  output logic               O_in_service,
  output logic               O_int_en,
  output logic [NUM_IRQ-1:0] O_pending
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_edge_pend;
  logic [NUM_IRQ-1:0] r_irq_hist;
  logic [IDW-1:0]     r_active_id;
  logic [13:0]        r_branch_addr;
  logic               r_int_en;
  logic               r_in_service;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_eligible;
  logic [IDW-1:0]     w_win;
  logic [13:0]        w_addr;
  logic               w_req;
  logic               w_ack;

  assign w_rise     = I_irq & ~r_irq_hist & EDGE_MASK;
  assign w_pending  = (I_irq & ~EDGE_MASK) | (r_edge_pend & EDGE_MASK);
  assign w_eligible = w_pending & r_mask;
  assign w_req      = (r_state == S_REQ) && !I_justBranched;
  assign w_ack      = w_req && I_int_ack && !I_stall;
  assign w_addr     = VEC_BASE + ({{(14-IDW){1'b0}}, w_win} * VEC_STRIDE);

  // Descending scan so the lowest set index ends up as the winner.
  always_comb begin
    w_win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_win = IDW'(i);
    end
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_clr[i] = w_ack && (r_active_id == IDW'(i)) && EDGE_MASK[i];
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state       <= S_IDLE;
      r_mask        <= '1;
      r_edge_pend   <= '0;
      r_irq_hist    <= '0;
      r_active_id   <= '0;
      r_branch_addr <= VEC_BASE;
      r_int_en      <= RESET_EN;
      r_in_service  <= 1'b0;
    end else begin
      r_irq_hist  <= I_irq;
      // A fresh edge in the ack cycle must survive the clear.
      r_edge_pend <= (r_edge_pend & ~w_clr) | w_rise;
      if (I_mask_we && !I_stall) r_mask <= I_mask_data;
      if (I_eint_valid && !I_stall) r_int_en <= I_eint_value;
      case (r_state)
        S_IDLE: begin
          if (r_int_en && (w_eligible != '0)) begin
            r_state       <= S_REQ;
            r_active_id   <= w_win;
            r_branch_addr <= w_addr;
          end
        end
        S_REQ: begin
          if (w_ack) begin
            r_state      <= S_SERVICE;
            r_int_en     <= 1'b0;
            r_in_service <= 1'b1;
          end
        end
        S_SERVICE: begin
          if (I_reti && !I_stall) begin
            r_state      <= S_IDLE;
            r_int_en     <= 1'b1;
            r_in_service <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign O_int_req       = w_req;
  assign O_branchAddress = r_branch_addr;
  assign O_active_id     = r_active_id;
  assign O_in_service    = r_in_service;
  assign O_int_en        = r_int_en;
  assign O_pending       = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_ceespu_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ceespu_int_ctrl
// Brief    : Directed-vector bench for ceespu_int_ctrl (line 3 edge, 0..2 level).
// Revision : 1.0
// ============================================================================
module tb_ceespu_int_ctrl;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic [3:0]  I_irq;
  logic        I_stall, I_justBranched, I_int_ack;
  logic        I_eint_valid, I_eint_value, I_reti;
  logic        I_mask_we;
  logic [3:0]  I_mask_data;
  logic        O_int_req;
  logic [13:0] O_branchAddress;
  logic [1:0]  O_active_id;
  logic        O_in_service, O_int_en;
  logic [3:0]  O_pending;

  int n_tests = 0;
  int n_fail  = 0;

  ceespu_int_ctrl #(
    .NUM_IRQ   (4),
    .EDGE_MASK (4'b1000),
    .VEC_BASE  (14'h0000),
    .VEC_STRIDE(14'h0004),
    .RESET_EN  (1'b1)
  ) u_dut (
    .I_clk          (I_clk),
    .I_rst          (I_rst),
    .I_irq          (I_irq),
    .I_stall        (I_stall),
    .I_justBranched (I_justBranched),
    .I_int_ack      (I_int_ack),
    .I_eint_valid   (I_eint_valid),
    .I_eint_value   (I_eint_value),
    .I_reti         (I_reti),
    .I_mask_we      (I_mask_we),
    .I_mask_data    (I_mask_data),
    .O_int_req      (O_int_req),
    .O_branchAddress(O_branchAddress),
    .O_active_id    (O_active_id),
    .O_in_service   (O_in_service),
    .O_int_en       (O_int_en),
    .O_pending      (O_pending)
  );

  always #5 I_clk = ~I_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  initial begin
    I_rst = 1'b1; I_irq = '0; I_stall = 0; I_justBranched = 0; I_int_ack = 0;
    I_eint_valid = 0; I_eint_value = 0; I_reti = 0; I_mask_we = 0; I_mask_data = '0;
    step(); step();
    I_rst = 1'b0;
    #1;
    chk("rst_req",  32'(O_int_req), 32'd0);
    chk("rst_insv", 32'(O_in_service), 32'd0);
    chk("rst_id",   32'(O_active_id), 32'd0);
    chk("rst_addr", 32'(O_branchAddress), 32'h0);
    chk("rst_en",   32'(O_int_en), 32'd1);
    chk("rst_pend", 32'(O_pending), 32'h0);

    // Level lines 1,2 -> id 1 next cycle
    I_irq = 4'b0110; #1;
    chk("lvl_pend", 32'(O_pending), 32'h6);
    step();
    chk("lvl_req",  32'(O_int_req), 32'd1);
    chk("lvl_id",   32'(O_active_id), 32'd1);
    chk("lvl_addr", 32'(O_branchAddress), 32'h4);

    // Line withdrawn, justBranched suppresses and blocks ack
    I_irq = 4'b0000; I_justBranched = 1; I_int_ack = 1; #1;
    chk("jb_req0", 32'(O_int_req), 32'd0);
    step();
    I_justBranched = 0; I_int_ack = 0; #1;
    chk("jb_req1", 32'(O_int_req), 32'd1);
    chk("jb_id",   32'(O_active_id), 32'd1);
    I_int_ack = 1; I_stall = 1;
    step();
    chk("stall_req", 32'(O_int_req), 32'd1);
    chk("stall_en",  32'(O_int_en), 32'd1);
    I_stall = 0;
    step();
    I_int_ack = 0; #1;
    chk("ack_insv", 32'(O_in_service), 32'd1);
    chk("ack_en",   32'(O_int_en), 32'd0);
    chk("ack_req",  32'(O_int_req), 32'd0);
    I_reti = 1; step(); I_reti = 0; #1;
    chk("reti_insv", 32'(O_in_service), 32'd0);
    chk("reti_en",   32'(O_int_en), 32'd1);
    chk("reti_req",  32'(O_int_req), 32'd0);

    // Edge line 3: one-cycle pulse is held
    I_irq = 4'b1000; step(); I_irq = 4'b0000; #1;
    chk("edge_pend", 32'(O_pending), 32'h8);
    step();
    chk("edge_hold", 32'(O_pending), 32'h8);
    chk("edge_req",  32'(O_int_req), 32'd1);
    chk("edge_id",   32'(O_active_id), 32'd3);
    chk("edge_addr", 32'(O_branchAddress), 32'hC);
    I_int_ack = 1; step(); I_int_ack = 0; #1;
    chk("edge_clr",  32'(O_pending), 32'h0);
    chk("edge_insv", 32'(O_in_service), 32'd1);
    I_reti = 1; step(); I_reti = 0;

    // Second edge coincident with ack keeps pending set
    I_irq = 4'b1000; step(); I_irq = 4'b0000; step();
    chk("edge2_req", 32'(O_int_req), 32'd1);
    I_int_ack = 1; I_irq = 4'b1000; step(); I_int_ack = 0; I_irq = 4'b0000; #1;
    chk("edge2_pend", 32'(O_pending), 32'h8);
    chk("edge2_insv", 32'(O_in_service), 32'd1);

    // No request in SERVICE; returns two cycles after reti with id 0
    I_irq = 4'b0001; step(); step();
    chk("svc_noreq", 32'(O_int_req), 32'd0);
    I_reti = 1; step(); I_reti = 0; #1;
    chk("svc_idle_req", 32'(O_int_req), 32'd0);
    step();
    chk("svc_ret_req",  32'(O_int_req), 32'd1);
    chk("svc_ret_id",   32'(O_active_id), 32'd0);
    chk("svc_ret_addr", 32'(O_branchAddress), 32'h0);
    I_int_ack = 1; step(); I_int_ack = 0; #1;
    chk("svc2_insv", 32'(O_in_service), 32'd1);

    // Reset inside SERVICE abandons the handler
    I_irq = 4'b0000; I_rst = 1; step(); I_rst = 0; #1;
    chk("rst_svc_insv", 32'(O_in_service), 32'd0);
    chk("rst_svc_en",   32'(O_int_en), 32'd1);
    chk("rst_svc_req",  32'(O_int_req), 32'd0);
    chk("rst_svc_pend", 32'(O_pending), 32'h0);

    // Mask and global enable gating
    I_mask_we = 1; I_mask_data = 4'b1110; step(); I_mask_we = 0;
    I_irq = 4'b0001; step();
    chk("mask_noreq", 32'(O_int_req), 32'd0);
    I_eint_valid = 1; I_eint_value = 0; step(); I_eint_valid = 0;
    I_irq = 4'b0100; step(); step();
    chk("eint0_req", 32'(O_int_req), 32'd0);
    chk("eint0_en",  32'(O_int_en), 32'd0);
    I_eint_valid = 1; I_eint_value = 1; step(); I_eint_valid = 0; #1;
    chk("eint1_en",  32'(O_int_en), 32'd1);
    chk("eint1_req", 32'(O_int_req), 32'd0);
    step();
    chk("eint1_req2", 32'(O_int_req), 32'd1);
    chk("eint1_id",   32'(O_active_id), 32'd2);
    chk("eint1_addr", 32'(O_branchAddress), 32'h8);

    // Disabling in REQ does not withdraw; ack beats a simultaneous EINT 1
    I_eint_valid = 1; I_eint_value = 0; step(); I_eint_valid = 0; #1;
    chk("nowd_req", 32'(O_int_req), 32'd1);
    chk("nowd_en",  32'(O_int_en), 32'd0);
    I_int_ack = 1; I_eint_valid = 1; I_eint_value = 1; step();
    I_int_ack = 0; I_eint_valid = 0; #1;
    chk("ovr_en",   32'(O_int_en), 32'd0);
    chk("ovr_insv", 32'(O_in_service), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
